npc_predict: RTL and testbench

Parametrised next-PC generator for the pipelined core: owns the fetch PC register and selects the next fetch address from sequential, predicted, or EX-stage-corrected targets. Control transfers resolve in EX using the codebase `NPC_*` encodings. An optional direct-mapped branch target buffer (BTB) with 2-bit counters predicts taken transfers at fetch. A mismatch between the prediction and the resolved outcome produces a one-cycle redirect to IF/ID.

---
 rtl/npc_predict.sv | 178 +++++++++++++++++
 tb/tb_npc_predict.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_predict.sv
// Next-PC generator: fetch PC register, EX-stage resolution/redirect and an
// optional direct-mapped BTB with 2-bit counters (enabled by NPC_BTB_EN).
module npc_predict #(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [2:0]      ex_op,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            ex_taken,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [XLEN-1:0] FOUR     = XLEN'(4);
  localparam logic [XLEN-1:0] LSB_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_ex_plus4;
  logic [XLEN-1:0] w_ex_rel;
  logic [XLEN-1:0] w_jalr_target;
  logic [XLEN-1:0] w_res_target;
  logic            w_actual_taken;
  logic            w_uncond;
  logic            w_mispredict;
  logic            w_redirect;
  logic [XLEN-1:0] w_pc_next;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;

  assign w_pc_plus4    = r_pc + FOUR;
  assign w_ex_plus4    = ex_pc + FOUR;
  assign w_ex_rel      = ex_pc + ex_imm;
  assign w_jalr_target = (ex_rs1 + ex_imm) & LSB_MASK;
  assign w_uncond      = (ex_op == NPC_JUMP) || (ex_op == NPC_JALR);

  always_comb begin
    w_res_target   = w_ex_plus4;
    w_actual_taken = 1'b0;
    case (ex_op)
      NPC_BRANCH: begin
        w_actual_taken = ex_taken;
        w_res_target   = ex_taken ? w_ex_rel : w_ex_plus4;
      end
      NPC_JUMP: begin
        w_actual_taken = 1'b1;
        w_res_target   = w_ex_rel;
      end
      NPC_JALR: begin
        w_actual_taken = 1'b1;
        w_res_target   = w_jalr_target;
      end
      default: begin
        w_actual_taken = 1'b0;
        w_res_target   = w_ex_plus4;
      end
    endcase
  end

  // A taken/taken pair still mispredicts when the targets disagree.
  assign w_mispredict = ex_valid &&
                        ((w_actual_taken != ex_pred_taken) ||
                         (w_actual_taken && (w_res_target != ex_pred_target)));
  assign w_redirect   = rstn && w_mispredict;

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_redirect) begin
      w_pc_next = w_res_target;
    end else if (stall) begin
      w_pc_next = r_pc;
    end else if (w_pred_taken) begin
      w_pc_next = w_pred_target;
    end else begin
      w_pc_next = w_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

`ifdef NPC_BTB_EN
  localparam int IDXW = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - IDXW - 2;

  logic            r_valid  [BTB_DEPTH];
  logic [TAGW-1:0] r_tag    [BTB_DEPTH];
  logic [XLEN-1:0] r_target [BTB_DEPTH];
  logic [1:0]      r_cnt    [BTB_DEPTH];
  logic            r_uncond [BTB_DEPTH];

  logic [IDXW-1:0] w_rd_idx;
  logic [TAGW-1:0] w_rd_tag;
  logic            w_rd_hit;
  logic [IDXW-1:0] w_ex_idx;
  logic [TAGW-1:0] w_ex_tag;
  logic            w_ex_hit;
  logic            w_upd;
  logic [1:0]      w_cnt_next;

  assign w_rd_idx = r_pc[IDXW+1:2];
  assign w_rd_tag = r_pc[XLEN-1:IDXW+2];
  assign w_rd_hit = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);

  assign w_pred_taken  = w_rd_hit && (r_uncond[w_rd_idx] || r_cnt[w_rd_idx][1]);
  assign w_pred_target = w_pred_taken ? r_target[w_rd_idx] : w_pc_plus4;

  assign w_ex_idx = ex_pc[IDXW+1:2];
  assign w_ex_tag = ex_pc[XLEN-1:IDXW+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_upd    = ex_valid && (ex_op != NPC_PLUS4);

  always_comb begin
    w_cnt_next = r_cnt[w_ex_idx];
    if (w_actual_taken) begin
      if (r_cnt[w_ex_idx] != 2'b11) w_cnt_next = r_cnt[w_ex_idx] + 2'b01;
    end else begin
      if (r_cnt[w_ex_idx] != 2'b00) w_cnt_next = r_cnt[w_ex_idx] - 2'b01;
    end
  end

  // Lookup reads the arrays asynchronously, so a same-cycle write is seen
  // only from the following cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= 2'b00;
      end
    end else if (w_upd) begin
      if (w_ex_hit) begin
        r_cnt[w_ex_idx]    <= w_cnt_next;
        r_uncond[w_ex_idx] <= w_uncond;
        if (w_actual_taken) r_target[w_ex_idx] <= w_res_target;
      end else if (w_actual_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= w_res_target;
        r_cnt[w_ex_idx]    <= 2'b10;
        r_uncond[w_ex_idx] <= w_uncond;
      end
    end
  end
`else
  // Static not-taken: every taken transfer is corrected from EX.
  assign w_pred_taken  = 1'b0;
  assign w_pred_target = w_pc_plus4;
`endif

  assign pc          = r_pc;
  assign pred_taken  = w_pred_taken;
  assign pred_target = w_pred_target;
  assign redirect    = w_redirect;
  assign redirect_pc = w_res_target;

endmodule

// File: tb/tb_npc_predict.sv
// Scoreboard bench for npc_predict: stimulus pushes model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_npc_predict;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef NPC_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  localparam logic [2:0] OP_PLUS4  = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JALR   = 3'b100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_op = 3'b000;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_imm = '0;
  logic [31:0] ex_rs1 = '0;
  logic        ex_taken = 1'b0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;

  npc_predict #(.XLEN(32), .BTB_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_taken(ex_taken),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
    logic        rd;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference model: fetch PC plus an abstract table of BTB entries.
  logic [31:0] m_pc;
  bit          m_v   [DEPTH];
  logic [31:0] m_tag [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  int          m_cnt [DEPTH];
  bit          m_unc [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_lookup(input logic [31:0] a, output bit t, output logic [31:0] tg);
    int idx;
    logic [31:0] tag;
    idx = int'((a / 32'd4) % 32'(DEPTH));
    tag = a / 32'(4 * DEPTH);
    t   = BTB_ON && m_v[idx] && (m_tag[idx] == tag) && (m_unc[idx] || m_cnt[idx] >= 2);
    tg  = t ? m_tgt[idx] : a + 32'd4;
  endfunction

  task automatic m_clear();
    m_pc = RST_PC;
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i]   = 1'b0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit v, input logic [2:0] op,
                       input logic [31:0] p, input logic [31:0] im, input logic [31:0] rs,
                       input bit tk, input bit pt, input logic [31:0] ptg);
    exp_t        e;
    bit          mp, act, mis;
    logic [31:0] mtg, res, tag;
    int          idx;
    rstn = r; stall = s; ex_valid = v; ex_op = op; ex_pc = p; ex_imm = im;
    ex_rs1 = rs; ex_taken = tk; ex_pred_taken = pt; ex_pred_target = ptg;
    m_lookup(m_pc, mp, mtg);
    case (op)
      OP_BRANCH: res = tk ? p + im : p + 32'd4;
      OP_JUMP:   res = p + im;
      OP_JALR:   res = (rs + im) & 32'hFFFF_FFFE;
      default:   res = p + 32'd4;
    endcase
    act = (op == OP_JUMP) || (op == OP_JALR) || ((op == OP_BRANCH) && tk);
    mis = v && ((act != pt) || (act && (res != ptg)));
    e.pc = m_pc; e.pt = mp; e.ptg = mtg; e.rd = r && mis; e.rpc = res;
    q.push_back(e);
    if (!r) begin
      m_clear();
    end else begin
      if (mis) m_pc = res;
      else if (!s) m_pc = mp ? mtg : m_pc + 32'd4;
      if (BTB_ON && v && (op != OP_PLUS4)) begin
        idx = int'((p / 32'd4) % 32'(DEPTH));
        tag = p / 32'(4 * DEPTH);
        if (m_v[idx] && (m_tag[idx] == tag)) begin
          m_cnt[idx] = act ? ((m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3)
                           : ((m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0);
          if (act) m_tgt[idx] = res;
          m_unc[idx] = (op == OP_JUMP) || (op == OP_JALR);
        end else if (act) begin
          m_v[idx] = 1'b1; m_tag[idx] = tag; m_tgt[idx] = res; m_cnt[idx] = 2;
          m_unc[idx] = (op == OP_JUMP) || (op == OP_JALR);
        end
      end
    end
  endtask

  task automatic idle(input bit s);
    drive(1'b1, s, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a fetch slot every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_txn++;
        chk("pc", pc, e.pc);
        chk("pred_taken", 32'(pred_taken), 32'(e.pt));
        chk("pred_target", pred_target, e.ptg);
        chk("redirect", 32'(redirect), 32'(e.rd));
        if (e.rd) chk("redirect_pc", redirect_pc, e.rpc);
        $display("txn %0d pc=%h pt=%0d ptg=%h rd=%0d rpc=%h",
                 n_txn, pc, pred_taken, pred_target, redirect, redirect_pc);
      end
    end
  end

  initial begin
    bit          r, s, v, tk, pt;
    logic [2:0]  op;
    logic [31:0] p, im, rs, ptg;
    logic [2:0]  ops [4];
    int          guard;
    ops[0] = OP_PLUS4; ops[1] = OP_BRANCH; ops[2] = OP_JUMP; ops[3] = OP_JALR;

    tick();
    m_clear();
    // Second reset cycle with a would-be mispredict that must stay masked.
    drive(1'b0, 1'b0, 1'b1, OP_JUMP, 32'h100, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pred", 32'(pred_taken), 32'h0);
    tick();
    chk("rst_pred_target", pred_target, 32'h4);

    for (int k = 0; k < 4; k++) begin
      chk("seq_pc", pc, 32'(k * 4));
      idle(1'b0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      tick();
      chk("stall_pc", pc, 32'h10);
    end
    idle(1'b0);
    tick();
    chk("stall_release_pc", pc, 32'h14);

    drive(1'b1, 1'b1, 1'b1, OP_BRANCH, 32'h20, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("br_redirect", 32'(redirect), 32'h1);
    chk("br_redirect_pc", redirect_pc, 32'h60);
    tick();
    chk("br_pc", pc, 32'h60);

    drive(1'b1, 1'b0, 1'b1, OP_JUMP, 32'h100, 32'hFFFF_FF20, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("fetch20_pc", pc, 32'h20);
    chk("fetch20_pred", 32'(pred_taken), 32'(BTB_ON));
    chk("fetch20_target", pred_target, BTB_ON ? 32'h60 : 32'h24);
    idle(1'b0);
    tick();
    chk("alias_pc", pc, BTB_ON ? 32'h60 : 32'h24);
    chk("alias_pred", 32'(pred_taken), 32'h0);
    idle(1'b0);
    tick();

    drive(1'b1, 1'b0, 1'b1, OP_JALR, 32'h200, 32'h10, 32'h1001, 1'b0, 1'b1, 32'h1000);
    #1;
    chk("jalr_redirect", 32'(redirect), 32'h1);
    chk("jalr_redirect_pc", redirect_pc, 32'h1010);
    tick();
    chk("jalr_pc", pc, 32'h1010);

    drive(1'b1, 1'b0, 1'b1, OP_BRANCH, 32'h20, 32'h40, 32'h0, 1'b0, 1'b1, 32'h60);
    #1;
    chk("train_redirect", 32'(redirect), 32'h1);
    chk("train_redirect_pc", redirect_pc, 32'h24);
    tick();
    drive(1'b1, 1'b0, 1'b1, OP_JUMP, 32'h100, 32'hFFFF_FF20, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("train_pc", pc, 32'h20);
    chk("train_pred", 32'(pred_taken), 32'h0);
    idle(1'b0);
    tick();

    drive(1'b1, 1'b0, 1'b1, OP_JUMP, 32'h100, 32'hFFFF_FEFC, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("wrap_top_pc", pc, 32'hFFFF_FFFC);
    idle(1'b0);
    tick();
    chk("wrap_pc", pc, 32'h0);

    // Reset mid-operation with a pending mispredict.
    drive(1'b0, 1'b0, 1'b1, OP_JUMP, 32'h100, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("midrst_redirect", 32'(redirect), 32'h0);
    tick();
    chk("midrst_pc", pc, RST_PC);

    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 99) >= 2);
      s  = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 9) < 6);
      op = ops[$urandom_range(0, 3)];
      case ($urandom_range(0, 9))
        0:       p = $urandom & 32'hFFFF_FFFC;
        1, 2, 3: p = m_pc;
        default: p = 32'($urandom_range(0, 3)) * 32'h400 + 32'($urandom_range(0, 31)) * 32'd4;
      endcase
      im = ($urandom_range(0, 19) == 0) ? $urandom
                                        : 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
      rs = 32'($urandom_range(0, 3)) * 32'h400 + 32'($urandom_range(0, 255)) * 32'd4
           + 32'($urandom_range(0, 1));
      tk = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 1) begin
        m_lookup(p, pt, ptg);
      end else begin
        pt  = $urandom_range(0, 1) == 1;
        ptg = p + 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
      end
      drive(r, s, v, op, p, im, rs, tk, pt, ptg);
      tick();
    end

    idle(1'b0);
    tick();
    guard = 0;
    while ((q.size() > 0) && (guard < 10)) begin
      @(posedge clk);
      guard++;
    end
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
